div_unit: RTL and testbench

Iterative 32-bit integer divider implementing RV32M `div`, `divu`, `rem` and `remu`. It sits in the execute stage beside the ALU and branch unit and consumes the same forwarded operands `SrcAE`/`SrcBE` and `funct3E`. It produces one quotient or remainder per accepted request. While it is busy, the hazard unit stalls F/D/E. The result joins the execute-stage result mux.

---
 rtl/div_if.sv | 23 ++
 rtl/div_unit.sv | 152 +++++++++++++++
 tb/tb_div_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Execute-stage request/response bundle for the iterative divider.
interface div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3E;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3E, SrcAE, SrcBE, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3E, SrcAE, SrcBE, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M div/divu/rem/remu, one quotient bit per cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned SHIFT_W = WIDTH + 1;
  localparam int unsigned TRIAL_W = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rem_sel_q, rem_sel_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic               accept_c;
  logic               signed_op_c;
  logic [WIDTH-1:0]   a_abs_c, b_abs_c;
  logic [WIDTH-1:0]   min_int_c;
  logic [SHIFT_W-1:0] r_sh_c;
  logic [TRIAL_W-1:0] trial_c;
  logic [WIDTH-1:0]   r_new_c, q_new_c;

  // Operand conditioning for a request presented this cycle
  always_comb begin
    accept_c    = bus.start && bus.funct3E[2] && !bus.flush &&
                  ((state_q == IDLE) || (state_q == DONE));
    signed_op_c = !bus.funct3E[0];
    min_int_c   = {1'b1, (WIDTH-1)'(0)};
    a_abs_c     = (signed_op_c && bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
    b_abs_c     = (signed_op_c && bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;
  end

  // One restoring step: shift {R,Q} left, subtract divisor, keep if non-negative
  always_comb begin
    r_sh_c  = {rem_q, quo_q[WIDTH-1]};
    trial_c = {1'b0, r_sh_c} - {2'b00, dvs_q};
    if (trial_c[TRIAL_W-1]) begin
      r_new_c = r_sh_c[WIDTH-1:0];
      q_new_c = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      r_new_c = trial_c[WIDTH-1:0];
      q_new_c = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    rem_sel_d = rem_sel_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept_c) begin
          rem_sel_d = bus.funct3E[1];
          if (bus.SrcBE == '0) begin
            result_d = bus.funct3E[1] ? bus.SrcAE : '1;
            state_d  = DONE;
          end else if (signed_op_c && (bus.SrcAE == min_int_c) && (bus.SrcBE == '1)) begin
            result_d = bus.funct3E[1] ? '0 : min_int_c;
            state_d  = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = a_abs_c;
            dvs_d     = b_abs_c;
            quo_neg_d = signed_op_c && (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
            rem_neg_d = signed_op_c && bus.SrcAE[WIDTH-1];
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          rem_d = r_new_c;
          quo_d = q_new_c;
          cnt_d = cnt_q + CNT_W'(1);
          // Final step: sign-fix and publish in the same edge that enters DONE
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d  = DONE;
            result_d = rem_sel_q ? (rem_neg_q ? -r_new_c : r_new_c)
                                 : (quo_neg_q ? -q_new_c : q_new_c);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      rem_sel_q <= rem_sel_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed RV32M divide vectors, flush, reset and back-to-back issue.
module tb_div_unit;

  localparam int unsigned WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;

  div_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned acc;
    int unsigned lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=done required=no_done result=0x%08h", bus.result);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  // Drive a request at a negedge; returns just after the sampling edge
  task automatic issue(input string name, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push,
                       input bit normal);
    exp_t e;
    bus.start   = 1'b1;
    bus.funct3E = fn;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) begin
      e.res  = exp;
      e.acc  = cyc;
      e.lat  = normal ? 32 : 0;
      e.name = name;
      sb.push_back(e);
    end
    check({name, "_busy"}, 32'(bus.busy), 32'(normal));
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=no_done required=done", name);
    end
  endtask

  task automatic run(input string name, input logic [2:0] fn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input bit normal);
    issue(name, fn, a, b, exp, 1'b1, normal);
    wait_done(name);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.funct3E = 3'b000;
    bus.SrcAE   = '0;
    bus.SrcBE   = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Non-M funct3 must not start anything
    issue("ignored_funct3", 3'b001, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("ignored_done", 32'(bus.done), 32'd0);

    run("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    run("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 1'b1);
    run("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    run("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    run("div_20_m3",  3'b100, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b1);
    run("rem_20_m3",  3'b110, 32'd20, 32'hFFFF_FFFD, 32'd2, 1'b1);
    run("div_5_0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run("rem_5_0",    3'b110, 32'd5, 32'd0, 32'd5, 1'b0);
    run("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    run("remu_min_m1", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Flush at E10 aborts silently; result keeps 0x80000000
    issue("flushed", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_result", bus.result, 32'h8000_0000);
    @(negedge clk);
    run("after_flush", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);

    // A start during CALC is ignored; the original op completes with normal latency
    issue("calc_start", 3'b101, 32'd1000, 32'd10, 32'd100, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3E = 3'b110;
    bus.SrcAE   = 32'd5;
    bus.SrcBE   = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("calc_start");
    @(negedge clk);

    // Asynchronous reset mid-CALC clears outputs immediately
    issue("reset_op", 3'b101, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b1);
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back: each new start is issued while the previous op is in DONE
    issue("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 1'b1, 1'b1);
    wait_done("divu_9_3");
    issue("b2b_rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("b2b_rem");
    issue("b2b_div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done("b2b_div0");
    @(negedge clk);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual=%0d outstanding required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
